// File: rtl/fp_accum_seq.sv
// Sums a stream of N single-precision floats around an external combinational FP adder.
// Each element takes 1+ADD_LAT cycles; zero operands and exact cancellation bypass the adder.
module fp_accum_seq #(
    parameter int LEN_W   = 8,
    parameter int ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      fpa_a,
    output logic [31:0]      fpa_b,
    input  logic [31:0]      fpa_result,
    output logic             sum_valid,
    output logic [31:0]      sum_out,
    input  logic             sum_ready,
    output logic             busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0]       LAT = 4'(ADD_LAT);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [1:0]       state;
    logic [31:0]      acc;
    logic [LEN_W-1:0] remaining;
    logic [3:0]       wait_cnt;
    logic [31:0]      next_acc;
    logic             a_zero;
    logic             b_zero;
    logic             cancel;

    // Denormals count as zero: only the exponent field is inspected.
    assign a_zero = (fpa_a[30:23] == 8'h00);
    assign b_zero = (fpa_b[30:23] == 8'h00);
    assign cancel = (fpa_a[30:0] == fpa_b[30:0]) && (fpa_a[31] != fpa_b[31]);

    always_comb begin
        next_acc = acc;
        if (b_zero) begin
            next_acc = acc;
        end else if (a_zero) begin
            next_acc = fpa_b;
        end else if (cancel) begin
            next_acc = 32'h0000_0000;
        end else begin
            next_acc = fpa_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= 32'h0;
            remaining <= '0;
            wait_cnt  <= 4'd0;
            fpa_a     <= 32'h0;
            fpa_b     <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= count;
                        acc       <= 32'h0;
                        state     <= (count == '0) ? S_DONE : S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        fpa_a     <= acc;
                        fpa_b     <= in_data;
                        remaining <= remaining - ONE;
                        wait_cnt  <= LAT;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        acc   <= next_acc;
                        state <= (remaining == '0) ? S_DONE : S_ACCEPT;
                    end
                end
                default: begin
                    if (sum_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state == S_ACCEPT);
    assign sum_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign sum_out   = acc;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a table-driven stand-in for the FP adder.
module tb_fp_accum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] fpa_a;
    logic [31:0] fpa_b;
    logic [31:0] fpa_result;
    logic        sum_valid;
    logic [31:0] sum_out;
    logic        sum_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    fp_accum_seq #(.LEN_W(8), .ADD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_result(fpa_result),
        .sum_valid(sum_valid), .sum_out(sum_out), .sum_ready(sum_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Only the sums this bench actually needs; anything else yields a poison value.
    always_comb begin
        case ({fpa_a, fpa_b})
            64'h3F800000_40000000: fpa_result = 32'h40400000;
            64'h40400000_40800000: fpa_result = 32'h40E00000;
            64'h40400000_3F800000: fpa_result = 32'h40800000;
            default:               fpa_result = 32'hDEADBEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start = 1'b1;
        count = n;
        step();
        start = 1'b0;
    endtask

    task automatic send(input string tag, input logic [31:0] d);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) check({tag, "_in_ready_wait"}, {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_sum(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 100; i++) begin
            if (sum_valid) break;
            step();
        end
        check({tag, "_sum_valid"}, {31'b0, sum_valid}, 32'd1);
        check({tag, "_sum_out"}, sum_out, exp);
    endtask

    task automatic release_sum();
        sum_ready = 1'b1;
        step();
        sum_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] vec [3];
        int rdy_cnt;
        int cyc;

        rst = 1'b1; start = 1'b0; count = 8'd0;
        in_valid = 1'b0; in_data = 32'h0; sum_ready = 1'b0;
        step();
        step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_sum_valid", {31'b0, sum_valid}, 32'd0);
        check("rst_sum_out", sum_out, 32'h0);
        check("rst_fpa_a", fpa_a, 32'h0);
        check("rst_fpa_b", fpa_b, 32'h0);
        rst = 1'b0;
        step();

        // Basic sum 1+2+4 with in_valid held high
        vec[0] = 32'h3F800000; vec[1] = 32'h40000000; vec[2] = 32'h40800000;
        rdy_cnt = 0;
        cyc = 0;
        do_start(8'd3);
        in_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (sum_valid) begin
                cyc = c;
                break;
            end
            if (in_ready) begin
                in_data = vec[rdy_cnt % 3];
                rdy_cnt++;
            end
            step();
        end
        in_valid = 1'b0;
        check("basic_latency", cyc, 32'd7);
        check("basic_ready_cycles", rdy_cnt, 32'd3);
        check("basic_sum_out", sum_out, 32'h40E00000);
        release_sum();
        check("basic_sum_valid_drop", {31'b0, sum_valid}, 32'd0);
        check("basic_idle", {31'b0, busy}, 32'd0);

        // Empty reduction
        do_start(8'd0);
        check("empty_sum_valid", {31'b0, sum_valid}, 32'd1);
        check("empty_sum_out", sum_out, 32'h0);
        release_sum();
        check("empty_idle", {31'b0, busy}, 32'd0);

        // Exact cancellation: adder table returns poison for this pair
        do_start(8'd2);
        send("cancel_e0", 32'h3F800000);
        send("cancel_e1", 32'hBF800000);
        check("cancel_fpa_a", fpa_a, 32'h3F800000);
        check("cancel_fpa_b", fpa_b, 32'hBF800000);
        wait_sum("cancel", 32'h0);
        release_sum();

        // Zero element must leave acc untouched
        do_start(8'd3);
        send("zero_e0", 32'h40400000);
        send("zero_e1", 32'h00000000);
        send("zero_e2", 32'h3F800000);
        check("zero_fpa_a", fpa_a, 32'h40400000);
        check("zero_fpa_b", fpa_b, 32'h3F800000);
        wait_sum("zero", 32'h40800000);
        release_sum();

        // Input stalls, start while busy, consumer backpressure
        do_start(8'd2);
        send("bp_e0", 32'h3F800000);
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            count = 8'd5;
            step();
        end
        start = 1'b0;
        check("bp_stall_in_ready", {31'b0, in_ready}, 32'd1);
        send("bp_e1", 32'h40000000);
        wait_sum("bp", 32'h40400000);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", {31'b0, sum_valid}, 32'd1);
            check("bp_hold_sum", sum_out, 32'h40400000);
        end
        release_sum();
        check("bp_idle", {31'b0, busy}, 32'd0);

        // Reset mid-run discards progress
        do_start(8'd4);
        send("rr_e0", 32'h3F800000);
        send("rr_e1", 32'h40000000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_busy", {31'b0, busy}, 32'd0);
        check("rr_in_ready", {31'b0, in_ready}, 32'd0);
        check("rr_sum_valid", {31'b0, sum_valid}, 32'd0);
        check("rr_acc", sum_out, 32'h0);
        step();
        check("rr_still_idle", {31'b0, busy}, 32'd0);
        do_start(8'd1);
        send("fresh_e0", 32'h41200000);
        wait_sum("fresh", 32'h41200000);
        release_sum();
        check("fresh_idle", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Sequential controller that sums a stream of N single-precision floats using the team's existing combinational FP adder as its arithmetic core.
- Sits directly around that adder. It drives both adder operands from a running-sum register and the incoming element, then captures the adder result back into that register.
- Handles the zero and exact-cancellation cases that the adder does not handle.
- Used by the FP datapath for reduction operations (dot-product tail, vector sum).

Parameters:
- LEN_W, 8, width of the element-count input; maximum N = 2^LEN_W - 1.
- ADD_LAT, 1, cycles held in WAIT after operands are registered before sampling fpa_result; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a reduction; sampled in IDLE only.
- count  input  LEN_W  number of elements; latched on start.
- in_valid  input  1  element available.
- in_data  input  32  IEEE-754 single element.
- in_ready  output  1  block accepts element this cycle.
- fpa_a  output  32  adder operand A (running sum), registered.
- fpa_b  output  32  adder operand B (element), registered.
- fpa_result  input  32  adder result.
- sum_valid  output  1  final sum available.
- sum_out  output  32  final sum.
- sum_ready  input  1  consumer takes sum.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, rst=1 at rising edge) forces:
  - state=IDLE; acc, remaining, wait counter, fpa_a, fpa_b, sum_out = 0.
  - in_ready, sum_valid, busy = 0.
  - rst asserted mid-operation discards all progress; no sum_valid is produced.
- Zero test: a value is zero when exp==0, regardless of mantissa. Denormals are flushed to zero.
- IDLE:
  - start=1 latches count into remaining and sets acc=32'h0.
  - Next state is DONE if count==0, otherwise ACCEPT.
- ACCEPT: in_ready=1 (Moore output). On in_valid&in_ready:
  - fpa_a<=acc, fpa_b<=in_data, remaining<=remaining-1.
  - Wait counter loads ADD_LAT; next state is WAIT.
  - With in_valid low, stay in ACCEPT indefinitely.
- WAIT: in_ready=0. The counter decrements each cycle. On the cycle it equals 1, acc is updated by the first matching rule:
  - fpa_b is zero -> acc unchanged.
  - fpa_a is zero -> acc<=fpa_b (sign preserved).
  - fpa_a[30:0]==fpa_b[30:0] and signs differ -> acc<=32'h0000_0000.
  - Otherwise -> acc<=fpa_result.
  - The same edge moves to DONE if remaining==0, else to ACCEPT.
- Per-element timing: every element, including bypassed ones, costs exactly 1+ADD_LAT cycles from acceptance to the next in_ready.
- DONE:
  - sum_valid=1 and sum_out=acc, held stable until sum_ready=1.
  - On sum_valid&sum_ready, next state is IDLE and sum_valid drops the following cycle.
- start while busy=1 is ignored; count changes while busy have no effect.
- fpa_a/fpa_b retain their last values outside WAIT.
- No rounding, overflow or NaN handling is added beyond what the adder produces; an Inf/NaN result passes through unchanged.
- busy=1 in ACCEPT, WAIT and DONE.
- Latency with ADD_LAT=1, zero stalls: sum_valid rises 2N+1 cycles after the start edge.

Test Plan:
- Basic sum: ADD_LAT=1, count=3, stream 3F800000, 40000000, 40800000, in_valid always high -> sum_out=40E00000 (7.0); sum_valid 7 cycles after start; in_ready high exactly 3 single cycles.
- Empty reduction: count=0, start pulse -> sum_valid the cycle after the start edge, sum_out=00000000; IDLE after sum_ready.
- Exact cancellation: count=2, 3F800000 then BF800000 -> sum_out=00000000. Confirm the adder output was ignored via the cancellation rule.
- Zero element: count=3, 40400000, 00000000, 3F800000 -> sum_out=40800000 (4.0). fpa_a/fpa_b must not present the zero as acc for the second element's addition.
- Backpressure and stalls: count=2 with in_valid low for 4 cycles between elements, sum_ready low 5 cycles -> sum_out stable across the stall, correct 40400000 for 3F800000+40000000. A start pulse during busy changes nothing.
- Reset mid-run: count=4, assert rst after 2 elements -> next cycle busy=0, in_ready=0, sum_valid=0, acc=0. A fresh run with count=1, 41200000 yields 41200000.
